// File: rtl/credit_allocator.sv
// Output-channel switch allocator: holds a grant for a whole packet and forwards
// flits only while the downstream buffer has credits.
module credit_allocator #(
  parameter int IN_N      = 5,
  parameter int ARB_TYPE  = 0,
  parameter int BUF_DEPTH = 4,
  localparam int CNT_W    = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IN_N-1:0]  req_i,
  input  logic [IN_N-1:0]  data_vld_i,
  input  logic [IN_N-1:0]  flit_id_is_tail_i,
  input  logic             credit_i,
  output logic [IN_N-1:0]  grant_o,
  output logic [IN_N-1:0]  rd_o,
  output logic             oc_vld_o,
  output logic [CNT_W-1:0] credits_o,
  output logic             busy_o,
  output logic             err_o,
  output logic             state_o
);

  // Handshake: a flit moves on the output channel in any cycle where oc_vld_o is
  // high; rd_o pops the granted FIFO in that same cycle. Nothing is back-pressured
  // except by the credit count, so there is no separate ready signal.

  localparam int PTR_W = (IN_N > 1) ? $clog2(IN_N) : 1;
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_ALLOC = 1'b1;
  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(BUF_DEPTH);

  logic             r_state;
  logic [IN_N-1:0]  r_grant;
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_credits;
  logic             r_err;

  logic [IN_N-1:0]  w_win;
  logic [PTR_W-1:0] w_gidx;
  logic [PTR_W-1:0] w_next_ptr;
  logic             w_sel_vld;
  logic             w_sel_tail;
  logic             w_xfer;

  // Rotating search from r_ptr for round-robin; fixed search from 0 for static.
  always_comb begin
    int   v_sum;
    logic v_found;
    logic [PTR_W-1:0] v_idx;
    w_win   = '0;
    v_found = 1'b0;
    v_sum   = 0;
    v_idx   = '0;
    for (int i = 0; i < IN_N; i++) begin
      if (ARB_TYPE == 0) begin
        v_sum = int'(r_ptr) + i;
        if (v_sum >= IN_N) v_sum = v_sum - IN_N;
      end else begin
        v_sum = i;
      end
      v_idx = v_sum[PTR_W-1:0];
      if (!v_found && req_i[v_idx]) begin
        w_win[v_idx] = 1'b1;
        v_found      = 1'b1;
      end
    end
  end

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < IN_N; i++) begin
      if (r_grant[i]) w_gidx = PTR_W'(i);
    end
  end

  assign w_next_ptr = (int'(w_gidx) == IN_N - 1) ? '0 : w_gidx + PTR_W'(1);
  assign w_sel_vld  = |(data_vld_i & r_grant);
  assign w_sel_tail = |(flit_id_is_tail_i & r_grant);
  assign w_xfer     = (r_state == ST_ALLOC) && w_sel_vld && (r_credits != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else if (r_state == ST_IDLE) begin
      if (|req_i) begin
        r_grant <= w_win;
        r_state <= ST_ALLOC;
      end
    end else begin
      if (w_xfer && w_sel_tail) begin
        r_grant <= '0;
        r_state <= ST_IDLE;
        r_ptr   <= w_next_ptr;
      end
    end
  end

  // A return with the counter already full and no flit leaving is an overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_credits <= CRED_MAX;
      r_err     <= 1'b0;
    end else if (w_xfer && !credit_i) begin
      r_credits <= r_credits - CNT_W'(1);
    end else if (!w_xfer && credit_i) begin
      if (r_credits == CRED_MAX) r_err <= 1'b1;
      else                       r_credits <= r_credits + CNT_W'(1);
    end
  end

  assign grant_o   = r_grant;
  assign rd_o      = w_xfer ? r_grant : '0;
  assign oc_vld_o  = w_xfer;
  assign credits_o = r_credits;
  assign busy_o    = (r_state == ST_ALLOC);
  assign err_o     = r_err;
  assign state_o   = r_state;

endmodule

// File: tb/tb_credit_allocator.sv
// Bench for credit_allocator: directed scenarios plus random traffic, checked
// against a packet-level reference model through expected-value queues.
module tb_credit_allocator;

  localparam int N   = 5;
  localparam int ARB = 0;
  localparam int BD  = 4;
  localparam int CW  = $clog2(BD + 1);
  localparam int SW  = 2 * N + CW + 4;
  localparam int XW  = N + CW;

  logic          clk;
  logic          rst_ni;
  logic [N-1:0]  req;
  logic [N-1:0]  vld;
  logic [N-1:0]  tail;
  logic          credit;
  logic [N-1:0]  grant_o;
  logic [N-1:0]  rd_o;
  logic          oc_vld_o;
  logic [CW-1:0] credits_o;
  logic          busy_o;
  logic          err_o;
  logic          state_o;

  credit_allocator #(.IN_N(N), .ARB_TYPE(ARB), .BUF_DEPTH(BD)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .data_vld_i(vld),
    .flit_id_is_tail_i(tail), .credit_i(credit), .grant_o(grant_o), .rd_o(rd_o),
    .oc_vld_o(oc_vld_o), .credits_o(credits_o), .busy_o(busy_o), .err_o(err_o),
    .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: granted input (-1 = none), RR pointer, credit count, error
  int m_g, m_ptr, m_cred;
  bit m_err;
  int n_cmp, n_bad;

  logic [SW-1:0] stat_q[$];
  logic [XW-1:0] xfer_q[$];

  function automatic int arb(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (ARB == 0) ? (p + i) % N : i;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  function automatic bit pred_xfer(input logic [N-1:0] v);
    return (m_g >= 0) && v[m_g] && (m_cred != 0);
  endfunction

  task automatic model_reset();
    m_g = -1; m_ptr = 0; m_cred = BD; m_err = 0;
  endtask

  // driver: one clock cycle of stimulus; pushes what the DUT must show this cycle
  task automatic cyc(input logic [N-1:0] rq, input logic [N-1:0] v,
                     input logic [N-1:0] tl, input logic cr);
    logic x;
    logic [N-1:0] oh;
    logic [N-1:0] rdv;
    @(posedge clk); #1;
    req = rq; vld = v; tail = tl; credit = cr;
    oh  = (m_g >= 0) ? (N'(1) << m_g) : '0;
    x   = pred_xfer(v);
    rdv = x ? oh : '0;
    stat_q.push_back({oh, rdv, x, CW'(m_cred), m_g >= 0, m_err, m_g >= 0});
    if (x) xfer_q.push_back({oh, CW'(m_cred)});
    if (m_g < 0) begin
      if (rq != '0) m_g = arb(rq, m_ptr);
    end else if (x && tl[m_g]) begin
      m_ptr = (m_g + 1) % N;
      m_g   = -1;
    end
    m_cred = m_cred - (x ? 1 : 0) + (cr ? 1 : 0);
    if (m_cred > BD) begin
      m_cred = BD;
      m_err  = 1;
    end
  endtask

  task automatic check_reset_vals(input string name);
    n_cmp++;
    if (grant_o !== '0 || rd_o !== '0 || oc_vld_o !== 1'b0 || busy_o !== 1'b0 ||
        credits_o !== CW'(BD) || err_o !== 1'b0 || state_o !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: grant=%b rd=%b vld=%b busy=%b cred=%0d err=%b st=%b, want 0 0 0 0 %0d 0 0",
               name, grant_o, rd_o, oc_vld_o, busy_o, credits_o, err_o, state_o, BD);
    end
  endtask

  // asynchronous reset asserted mid-cycle, checked before any clock edge
  task automatic do_reset(input string name);
    @(posedge clk); #3;
    rst_ni = 1'b0;
    #1;
    check_reset_vals(name);
    stat_q.delete();
    xfer_q.delete();
    model_reset();
    req = '0; vld = '0; tail = '0; credit = 1'b0;
    @(negedge clk); #1;
    rst_ni = 1'b1;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_ni) begin
      if (stat_q.size() > 0) begin
        logic [SW-1:0] e, a;
        e = stat_q.pop_front();
        a = {grant_o, rd_o, oc_vld_o, credits_o, busy_o, err_o, state_o};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL status @%0t: got grant=%b rd=%b vld=%b cred=%0d busy=%b err=%b st=%b, want %b",
                   $time, grant_o, rd_o, oc_vld_o, credits_o, busy_o, err_o, state_o, e);
        end
      end
      if (oc_vld_o) begin
        n_cmp++;
        if (xfer_q.size() == 0) begin
          n_bad++;
          $display("FAIL flit @%0t: unexpected flit rd=%b, want none", $time, rd_o);
        end else begin
          logic [XW-1:0] ex;
          ex = xfer_q.pop_front();
          if ({rd_o, credits_o} !== ex) begin
            n_bad++;
            $display("FAIL flit @%0t: got rd=%b cred=%0d, want rd=%b cred=%0d",
                     $time, rd_o, credits_o, ex[XW-1:CW], ex[CW-1:0]);
          end
        end
      end
    end
  end

  initial begin
    int sent;
    n_cmp = 0; n_bad = 0;
    req = '0; vld = '0; tail = '0; credit = 1'b0;
    rst_ni = 1'b0;
    model_reset();
    #12;
    check_reset_vals("reset_state");
    @(negedge clk); #1;
    rst_ni = 1'b1;

    // 3-flit packet on input 2
    cyc(5'b00100, '0, '0, 1'b0);
    cyc('0, 5'b00100, '0, 1'b0);
    cyc('0, 5'b00100, '0, 1'b0);
    cyc('0, 5'b00100, 5'b00100, 1'b0);
    cyc('0, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cyc('0, '0, '0, 1'b1);

    // round-robin among 0,1,4 with single-flit packets and matching credit returns
    for (int i = 0; i < 12; i++) cyc(5'b10011, '1, '1, pred_xfer('1));
    cyc('0, '0, '0, 1'b0);

    // 6-flit packet on input 0 stalling on credits, then two returns
    sent = 0;
    cyc(5'b00001, '0, '0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      logic x;
      x = pred_xfer(5'b00001);
      cyc('0, 5'b00001, (sent == 5) ? 5'b00001 : '0, (i == 6) || (i == 8));
      if (x) sent++;
    end

    // credits to 2, then consume and return in the same cycles, incl. tail
    cyc('0, '0, '0, 1'b1);
    cyc('0, '0, '0, 1'b1);
    cyc(5'b00010, '0, '0, 1'b0);
    cyc('0, 5'b00010, '0, 1'b1);
    cyc('0, 5'b00010, 5'b00010, 1'b1);
    cyc('0, '0, '0, 1'b0);

    // overflow at full count, then one flit
    cyc('0, '0, '0, 1'b1);
    cyc('0, '0, '0, 1'b1);
    cyc('0, '0, '0, 1'b1);
    cyc(5'b01000, '0, '0, 1'b0);
    cyc('0, 5'b01000, 5'b01000, 1'b0);
    cyc('0, '0, '0, 1'b0);

    // reset mid-packet after 2 of 4 flits, then arbitration restarts from 0
    cyc(5'b01000, '0, '0, 1'b0);
    cyc('0, 5'b01000, '0, 1'b0);
    cyc('0, 5'b01000, '0, 1'b0);
    do_reset("reset_mid_packet");
    cyc(5'b10010, '0, '0, 1'b0);
    cyc('0, 5'b00010, 5'b00010, 1'b0);
    cyc(5'b10010, '0, '0, 1'b0);
    cyc('0, 5'b10000, 5'b10000, 1'b0);
    cyc('0, '0, '0, 1'b0);

    // random traffic in a few segments
    for (int s = 0; s < 3; s++) begin
      do_reset("reset_segment");
      for (int i = 0; i < 300; i++) begin
        logic [N-1:0] v;
        v = N'($urandom) | N'($urandom);
        cyc(N'($urandom), v, N'($urandom) & N'($urandom), $urandom_range(0, 2) == 0);
      end
    end
    cyc('0, '0, '0, 1'b0);
    @(posedge clk); #1;

    n_cmp++;
    if (stat_q.size() != 0 || xfer_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d status and %0d flits left, want 0 and 0",
               stat_q.size(), xfer_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
